// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer rectangle-fill controller.
// Holds the default raster geometry and field widths, the 2-bit color code,
// and the fill FSM state encoding.
package fb_pkg;

   localparam int HD_DEFAULT = 1280;  // horizontal active pixels
   localparam int VD_DEFAULT = 1024;  // vertical active lines
   localparam int XW_DEFAULT = 11;    // x address / width field width
   localparam int YW_DEFAULT = 11;    // y address / height field width
   localparam int CW_DEFAULT = 2;     // color code width

   typedef enum logic [CW_DEFAULT-1:0] {
      BLACK = 2'd0,
      WHITE = 2'd1,
      BLUE  = 2'd2,
      GREEN = 2'd3
   } color_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CLIP = 2'd1,
      ST_FILL = 2'd2
   } fill_state_e;

endpackage

// File: rtl/fb_wr_mux.sv
// Registered 2:1 priority mux in front of the frame-buffer write port.
// The host pixel path always wins; the fill path is told through fill_grant_o
// whether its pixel was taken this cycle, so it can hold its position on a
// stall. Outputs appear one cycle after the request. Address/color outputs
// keep their last written value on cycles without a write.
//
// Ports:
//   clk_i, arstn_i          clock, async active-low reset
//   host_we_i/addr/color    direct host pixel write request
//   fill_req_i/x/y/color    fill engine pixel write request
//   fill_grant_o            fill request accepted this cycle (combinational)
//   fb_we_o/addr/color      registered frame-buffer write port
module fb_wr_mux #(
   parameter int XW = fb_pkg::XW_DEFAULT,
   parameter int YW = fb_pkg::YW_DEFAULT,
   parameter int CW = fb_pkg::CW_DEFAULT
) (
   input  logic          clk_i,
   input  logic          arstn_i,
   input  logic          host_we_i,
   input  logic [XW-1:0] host_addr_x_i,
   input  logic [YW-1:0] host_addr_y_i,
   input  logic [CW-1:0] host_color_i,
   input  logic          fill_req_i,
   input  logic [XW-1:0] fill_x_i,
   input  logic [YW-1:0] fill_y_i,
   input  logic [CW-1:0] fill_color_i,
   output logic          fill_grant_o,
   output logic          fb_we_o,
   output logic [XW-1:0] fb_addr_x_o,
   output logic [YW-1:0] fb_addr_y_o,
   output logic [CW-1:0] fb_color_o
);

   assign fill_grant_o = fill_req_i & ~host_we_i;

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         fb_we_o     <= 1'b0;
         fb_addr_x_o <= '0;
         fb_addr_y_o <= '0;
         fb_color_o  <= '0;
      end else begin
         fb_we_o <= host_we_i | fill_req_i;
         if (host_we_i) begin
            fb_addr_x_o <= host_addr_x_i;
            fb_addr_y_o <= host_addr_y_i;
            fb_color_o  <= host_color_i;
         end else if (fill_req_i) begin
            fb_addr_x_o <= fill_x_i;
            fb_addr_y_o <= fill_y_i;
            fb_color_o  <= fill_color_i;
         end
      end
   end

endmodule

// File: rtl/fb_rect_fill_ctrl.sv
// Rectangle-fill controller for the 2bpp VGA frame buffer.
// Accepts a fill command (x0, y0, w, h, color) when cmd_ready_o is high,
// clips the rectangle to the active raster, then writes one pixel per cycle
// in raster order. A direct host pixel write shares the same frame-buffer
// port and always takes priority, stalling the fill for that cycle.
//
// Handshake: a command transfers on a rising edge where cmd_valid_i and
// cmd_ready_o are both high; cmd_ready_o is high only in IDLE, so commands
// are never queued behind a running fill.
//
// Ports:
//   clk_i, arstn_i        clock, async active-low reset
//   cmd_*                 fill command handshake and fields
//   abort_i               cancel the running fill (ignored in IDLE)
//   host_*                direct host pixel write (priority path)
//   fb_*                  registered frame-buffer write port
//   busy_o                controller not in IDLE
//   done_o                one-cycle pulse with the last pixel of a normal fill
//   dbg_state_o           current FSM state, for observation only
module fb_rect_fill_ctrl
   import fb_pkg::*;
#(
   parameter int HD = HD_DEFAULT,
   parameter int VD = VD_DEFAULT,
   parameter int XW = XW_DEFAULT,
   parameter int YW = YW_DEFAULT,
   parameter int CW = CW_DEFAULT
) (
   input  logic          clk_i,
   input  logic          arstn_i,
   input  logic          cmd_valid_i,
   output logic          cmd_ready_o,
   input  logic [XW-1:0] cmd_x0_i,
   input  logic [YW-1:0] cmd_y0_i,
   input  logic [XW-1:0] cmd_w_i,
   input  logic [YW-1:0] cmd_h_i,
   input  logic [CW-1:0] cmd_color_i,
   input  logic          abort_i,
   input  logic          host_we_i,
   input  logic [XW-1:0] host_addr_x_i,
   input  logic [YW-1:0] host_addr_y_i,
   input  logic [CW-1:0] host_color_i,
   output logic          fb_we_o,
   output logic [XW-1:0] fb_addr_x_o,
   output logic [YW-1:0] fb_addr_y_o,
   output logic [CW-1:0] fb_color_o,
   output logic          busy_o,
   output logic          done_o,
   output fill_state_e   dbg_state_o
);

   // Clip limits held one bit wider than the fields so x0+w never wraps.
   localparam logic [XW:0] HD_X = (XW+1)'(HD);
   localparam logic [YW:0] VD_Y = (YW+1)'(VD);

   fill_state_e   state_q, state_d;

   logic [XW-1:0] x0_q, w_q, x_q;
   logic [YW-1:0] y0_q, h_q, y_q;
   logic [CW-1:0] color_q;
   logic [XW:0]   x_last_q;
   logic [YW:0]   y_last_q;
   logic          done_q, done_d;

   logic [XW:0]   x_sum, x_end, x_last_d;
   logic [YW:0]   y_sum, y_end, y_last_d;
   logic          clip_empty;
   logic          fill_req, fill_grant;
   logic          at_row_end, at_last_px;

   // ---------------------------------------------------------------------
   // Clip arithmetic, evaluated during CLIP on the latched command.
   // ---------------------------------------------------------------------
   always_comb begin
      x_sum    = {1'b0, x0_q} + {1'b0, w_q};
      y_sum    = {1'b0, y0_q} + {1'b0, h_q};
      x_end    = (x_sum > HD_X) ? HD_X : x_sum;
      y_end    = (y_sum > VD_Y) ? VD_Y : y_sum;
      x_last_d = x_end - (XW+1)'(1);
      y_last_d = y_end - (YW+1)'(1);
      // An empty rectangle (or one starting off-screen) finishes with no
      // writes; x_last/y_last are meaningless in that case.
      clip_empty = (w_q == '0) || (h_q == '0) ||
                   ({1'b0, x0_q} >= HD_X) || ({1'b0, y0_q} >= VD_Y);
   end

   assign at_row_end = ({1'b0, x_q} == x_last_q);
   assign at_last_px = at_row_end && ({1'b0, y_q} == y_last_q);

   // Abort suppresses the request in the same cycle, so nothing from the
   // aborted fill reaches the frame buffer after the aborting edge.
   assign fill_req = (state_q == ST_FILL) && !abort_i;

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state_q <= ST_IDLE;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next state and done pulse
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid_i) state_d = ST_CLIP;
         end
         ST_CLIP: begin
            if (abort_i) begin
               state_d = ST_IDLE;
            end else if (clip_empty) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = ST_FILL;
            end
         end
         ST_FILL: begin
            if (abort_i) begin
               state_d = ST_IDLE;
            end else if (fill_grant && at_last_px) begin
               // done is registered, so it lines up with the registered
               // write of the last pixel.
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Command latch and raster position counters
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         x0_q     <= '0;
         y0_q     <= '0;
         w_q      <= '0;
         h_q      <= '0;
         color_q  <= '0;
         x_q      <= '0;
         y_q      <= '0;
         x_last_q <= '0;
         y_last_q <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (cmd_valid_i) begin
                  x0_q    <= cmd_x0_i;
                  y0_q    <= cmd_y0_i;
                  w_q     <= cmd_w_i;
                  h_q     <= cmd_h_i;
                  color_q <= cmd_color_i;
               end
            end
            ST_CLIP: begin
               x_q      <= x0_q;
               y_q      <= y0_q;
               x_last_q <= x_last_d;
               y_last_q <= y_last_d;
            end
            ST_FILL: begin
               // Position only moves when the mux took our pixel.
               if (fill_grant) begin
                  if (at_row_end) begin
                     x_q <= x0_q;
                     y_q <= y_q + YW'(1);
                  end else begin
                     x_q <= x_q + XW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Shared write port
   // ---------------------------------------------------------------------
   fb_wr_mux #(
      .XW (XW),
      .YW (YW),
      .CW (CW)
   ) u_wr_mux (
      .clk_i         (clk_i),
      .arstn_i       (arstn_i),
      .host_we_i     (host_we_i),
      .host_addr_x_i (host_addr_x_i),
      .host_addr_y_i (host_addr_y_i),
      .host_color_i  (host_color_i),
      .fill_req_i    (fill_req),
      .fill_x_i      (x_q),
      .fill_y_i      (y_q),
      .fill_color_i  (color_q),
      .fill_grant_o  (fill_grant),
      .fb_we_o       (fb_we_o),
      .fb_addr_x_o   (fb_addr_x_o),
      .fb_addr_y_o   (fb_addr_y_o),
      .fb_color_o    (fb_color_o)
   );

   assign cmd_ready_o = (state_q == ST_IDLE);
   assign busy_o      = (state_q != ST_IDLE);
   assign done_o      = done_q;
   assign dbg_state_o = state_q;

endmodule

// File: doc/fb_rect_fill_ctrl.md
Name: fb_rect_fill_ctrl

Overview:
Write-port controller for the 2-bit-per-pixel frame buffer in the VGA top level. It accepts rectangle-fill commands over a valid/ready handshake and sequences one frame-buffer write per cycle in raster order. It shares the single frame-buffer write port with a direct host pixel-write path, and the host always has priority. It sits between the host/command interface and the frame buffer's we/addr_x/addr_y/color inputs.

Parameters:
HD, 1280, horizontal active pixels; x clip limit
VD, 1024, vertical active lines; y clip limit
XW, 11, x address / width field width
YW, 11, y address / height field width
CW, 2, color code width (BLACK=0, WHITE=1, BLUE=2, GREEN=3)

Ports:
clk_i  in  1  clock
arstn_i  in  1  asynchronous reset, active-low
cmd_valid_i  in  1  fill command valid
cmd_ready_o  out  1  controller can accept a command
cmd_x0_i  in  XW  rectangle left x
cmd_y0_i  in  YW  rectangle top y
cmd_w_i  in  XW  rectangle width in pixels
cmd_h_i  in  YW  rectangle height in lines
cmd_color_i  in  CW  fill color code
abort_i  in  1  cancel the current fill
host_we_i  in  1  direct host pixel write
host_addr_x_i  in  XW  host x
host_addr_y_i  in  YW  host y
host_color_i  in  CW  host color
fb_we_o  out  1  frame-buffer write enable
fb_addr_x_o  out  XW  frame-buffer x
fb_addr_y_o  out  YW  frame-buffer y
fb_color_o  out  CW  frame-buffer color
busy_o  out  1  controller not in IDLE
done_o  out  1  one-cycle pulse: fill finished normally

Behaviour:
- Reset values: fb_we_o=0, fb_addr_x_o=0, fb_addr_y_o=0, fb_color_o=0, busy_o=0, done_o=0, cmd_ready_o=1. State goes to IDLE.
- All fb_* outputs are registered. Latency from a request (host or fill pixel) to fb_* is 1 cycle.
- FSM has three states: IDLE, CLIP, FILL.
- IDLE:
  - cmd_ready_o=1.
  - When cmd_valid_i=1, the command fields are latched and the state moves to CLIP.
- CLIP (1 cycle):
  - Compute x_last = min(x0+w, HD)-1 and y_last = min(y0+h, VD)-1, using XW+1 / YW+1 bit sums so there is no overflow.
  - Load x=x0, y=y0.
  - If w=0, h=0, x0>=HD or y0>=VD: go to IDLE and pulse done_o with no writes issued.
  - Otherwise go to FILL.
- FILL:
  - Each cycle with host_we_i=0: issue a write of (x, y, color) and advance the position.
  - Advance rule: x++; when x==x_last, set x=x0 and y++.
  - Cycles with host_we_i=1 stall the fill (position held) and issue the host write instead.
  - The write of (x_last, y_last) is the last one. It moves the state to IDLE, and done_o=1 in the same cycle that write appears on fb_*.
- busy_o=1 in CLIP and FILL. cmd_ready_o=0 in CLIP and FILL; commands are never queued.
- Host writes in IDLE or CLIP pass straight through with the 1-cycle latency.
- abort_i=1 in CLIP or FILL:
  - The next edge forces IDLE and no fill write is issued from that edge on.
  - done_o is not pulsed.
  - Pixels already written stay written.
  - abort_i in IDLE has no effect.
- abort_i and cmd_valid_i in the same IDLE cycle: the command is accepted.
- A host write and the last fill pixel in the same cycle: the host write wins; the last pixel goes out in the next free cycle, then done_o pulses.
- Reset mid-fill: immediate IDLE with all outputs at reset values; the fill is lost.
- Total fill cycles with no host traffic: 1 (CLIP) + clipped_w*clipped_h.

Decomposition:
- Shared package fb_pkg holds:
  - the color enum (BLACK, WHITE, BLUE, GREEN) at width CW;
  - HD/VD defaults;
  - the fill FSM state enum.
- One natural sub-module is fb_wr_mux: the registered 2:1 priority mux (host over fill) driving fb_*, which also returns a fill_grant signal.
- The FSM and address counters stay in the top module.

Test Plan:
- Fill x0=10, y0=20, w=3, h=2, color=GREEN, no host traffic -> 6 writes in consecutive cycles: (10,20) (11,20) (12,20) (10,21) (11,21) (12,21), all with fb_color_o=3. done_o coincides with (12,21). busy_o is high for 7 cycles.
- Clip case x0=1278, y0=1023, w=5, h=4 -> exactly 2 writes, (1278,1023) and (1279,1023), then done_o.
- Degenerate cases w=0, and separately x0=1280 -> zero writes; done_o pulses 2 cycles after the handshake.
- Fill 4x1 at (0,0) with host_we_i held high for 2 cycles mid-fill at host (100,100) -> the host writes appear in order, the fill resumes at the held x, 4 fill writes in total, and done_o is delayed by 2 cycles.
- Abort after 5 writes of a 10x10 fill -> no further fill writes, no done_o, and cmd_ready_o=1 on the next cycle.
- arstn_i asserted during FILL -> all outputs 0 asynchronously, cmd_ready_o=1 after release, and a new command is accepted normally.
